// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity encodings, FSM states and
// the clock-to-tick divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PAR      = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    // Rounded clocks per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int step;
        step = baud * os;
        return (clk_freq + step / 2) / step;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side character stream: head-of-FIFO data/flags with valid/ready.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic [1:0]           m_err;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, output m_err, output m_valid, input m_ready);
    modport slave  (input m_data, input m_err, input m_valid, output m_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO; writes into a full FIFO are dropped and flagged.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, wr_ok, rd_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign valid   = (level != '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && valid;
    // Output forced to zero when empty so nothing stale is ever presented.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_en && full;
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority voting, parity/frame/break
// detection and a FWFT character FIFO.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    uart_rx_core_if.master                m,
    output logic                          overrun,
    output logic                          break_det,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int TC_W = $clog2(OVERSAMPLE);
    localparam int MID  = OVERSAMPLE / 2;

    rx_state_t            state_q, state_d;
    logic                 rx_meta, rx_sync, rx_prev, armed;
    logic [1:0]           flush;
    logic [DIV_W-1:0]     div_cnt;
    logic [TC_W-1:0]      tick_cnt;
    logic [3:0]           bit_cnt;
    logic                 s0, s1, par_bit, stop_err;
    logic [DATA_BITS-1:0] data_sh;
    logic                 tick, samp, maj, fall, is_break, perr, ferr, wr_en, brk;
    logic [DATA_BITS+1:0] rd_word;

    assign tick = (state_q != IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign samp = tick && (tick_cnt == TC_W'(MID + 1));
    assign maj  = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
    // The line must be seen idle after reset before a start edge counts,
    // so a frame interrupted by reset cannot be picked up half-way.
    assign fall = armed && rx_prev && !rx_sync;
    assign is_break = !maj && (data_sh == '0) && (PARITY == PAR_NONE || !par_bit);
    assign perr = (PARITY == PAR_NONE) ? 1'b0
                : (par_bit != ((^data_sh) ^ (PARITY == PAR_ODD)));
    assign ferr = stop_err | !maj;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        brk     = 1'b0;
        case (state_q)
            IDLE:     if (fall) state_d = START;
            START:    if (samp) state_d = maj ? IDLE : DATA;
            DATA:     if (samp && bit_cnt == 4'(DATA_BITS - 1))
                          state_d = (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:      if (samp) state_d = STOP;
            STOP: begin
                if (samp) begin
                    if (bit_cnt == 4'd0 && is_break) begin
                        brk     = 1'b1;
                        state_d = BRK_WAIT;
                    end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BRK_WAIT: if (rx_sync) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            armed     <= 1'b0;
            flush     <= 2'd0;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            data_sh   <= '0;
            par_bit   <= 1'b0;
            stop_err  <= 1'b0;
            break_det <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            break_det <= brk;
            if (!flush[1]) flush <= flush + 2'd1;
            armed <= armed | (flush[1] & rx_sync);
            if (state_q == IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                stop_err <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) tick_cnt <= tick_cnt + TC_W'(1);
                if (tick && tick_cnt == TC_W'(MID - 1)) s0 <= rx_sync;
                if (tick && tick_cnt == TC_W'(MID))     s1 <= rx_sync;
                if (samp) begin
                    case (state_q)
                        DATA: begin
                            data_sh <= {maj, data_sh[DATA_BITS-1:1]};
                            bit_cnt <= (bit_cnt == 4'(DATA_BITS - 1)) ? 4'd0 : bit_cnt + 4'd1;
                        end
                        PAR:  par_bit <= maj;
                        STOP: begin
                            stop_err <= ferr;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data ({perr, ferr, data_sh}),
        .rd_en   (m.m_ready),
        .rd_data (rd_word),
        .valid   (m.m_valid),
        .level   (fifo_level),
        .overrun (overrun)
    );

    assign m.m_data = rd_word[DATA_BITS-1:0];
    assign m.m_err  = rd_word[DATA_BITS+1:DATA_BITS];
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench: default 8N1 receiver, a fast-clock copy for FIFO fill/overrun
// and an even-parity copy.
module tb_uart_rx_core;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic ov0, ov1, ov2, brk0, brk1, brk2;
    logic [4:0] lvl0, lvl1, lvl2;
    int checks = 0;
    int errors = 0;
    int brk_cnt0 = 0;
    int ov_cnt1 = 0;

    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_core_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_core_if #(.DATA_BITS(8)) bus2 ();

    uart_rx_core dut0 (.clk(clk), .rst_n(rst_n), .rx(rx0), .m(bus0),
                       .overrun(ov0), .break_det(brk0), .fifo_level(lvl0));
    uart_rx_core #(.CLK_FREQ(7372800)) dut1 (.clk(clk), .rst_n(rst_n), .rx(rx1), .m(bus1),
                       .overrun(ov1), .break_det(brk1), .fifo_level(lvl1));
    uart_rx_core #(.PARITY(1)) dut2 (.clk(clk), .rst_n(rst_n), .rx(rx2), .m(bus2),
                       .overrun(ov2), .break_det(brk2), .fifo_level(lvl2));

    always @(posedge clk) begin
        if (brk0) brk_cnt0 <= brk_cnt0 + 1;
        if (ov1)  ov_cnt1  <= ov_cnt1 + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic [1:0] exp_err;
        int         exp_lvl;
        int         exp_brk;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int ln, input logic v);
        case (ln)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic send(input int ln, input logic [7:0] d, input bit par_en,
                        input logic pb, input logic stop);
        logic [10:0] bits;
        int n, bclk;
        bclk = (ln == 1) ? 64 : 434;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
        if (par_en) begin bits[n] = pb; n++; end
        bits[n] = stop; n++;
        for (int i = 0; i < n; i++) begin
            set_line(ln, bits[i]);
            repeat (bclk) @(negedge clk);
        end
        set_line(ln, 1'b1);
    endtask

    task automatic pop(input int ln);
        if (ln == 0) bus0.m_ready = 1'b1;
        else if (ln == 1) bus1.m_ready = 1'b1;
        else bus2.m_ready = 1'b1;
        @(negedge clk);
        bus0.m_ready = 1'b0;
        bus1.m_ready = 1'b0;
        bus2.m_ready = 1'b0;
    endtask

    initial begin
        int b, o;
        logic [7:0] f81;
        bus0.m_ready = 1'b0;
        bus1.m_ready = 1'b0;
        bus2.m_ready = 1'b0;

        tbl[0] = '{8'hA5, 1'b1, 8'hA5, 2'b00, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 8'h00, 2'b00, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 8'hFF, 2'b00, 1, 0};
        tbl[3] = '{8'h55, 1'b0, 8'h55, 2'b01, 1, 0};
        tbl[4] = '{8'h00, 1'b0, 8'h00, 2'b00, 0, 1};

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_level", int'(lvl0), 0);
        chk("rst_valid", int'(bus0.m_valid), 0);
        chk("rst_data", int'(bus0.m_data), 0);
        chk("rst_err", int'(bus0.m_err), 0);
        chk("rst_overrun", int'(ov0), 0);
        chk("rst_break", int'(brk0), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Short glitch must be rejected as a false start
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        repeat (500) @(negedge clk);
        chk("glitch_level", int'(lvl0), 0);
        chk("glitch_state", int'(dut0.state_q), int'(IDLE));

        for (int i = 0; i < 5; i++) begin
            b = brk_cnt0;
            send(0, tbl[i].data, 1'b0, 1'b0, tbl[i].stop);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_data", i), int'(bus0.m_data), int'(tbl[i].exp_data));
            chk($sformatf("vec%0d_err", i), int'(bus0.m_err), int'(tbl[i].exp_err));
            chk($sformatf("vec%0d_level", i), int'(lvl0), tbl[i].exp_lvl);
            chk($sformatf("vec%0d_break", i), brk_cnt0 - b, tbl[i].exp_brk);
            if (tbl[i].exp_lvl != 0) pop(0);
        end

        // Line held low for two frame times: a single break pulse
        b = brk_cnt0;
        rx0 = 1'b0;
        repeat (8680) @(negedge clk);
        rx0 = 1'b1;
        repeat (50) @(negedge clk);
        chk("long_break_pulses", brk_cnt0 - b, 1);
        chk("long_break_level", int'(lvl0), 0);

        // Reset during data bit 4 of 0x81, then a clean 0x7E
        f81 = 8'h81;
        for (int i = 0; i < 10; i++) begin
            rx0 = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : f81[i-1];
            if (i == 5) begin
                repeat (200) @(negedge clk);
                rst_n = 1'b0;
                repeat (10) @(negedge clk);
                chk("midrst_level", int'(lvl0), 0);
                chk("midrst_valid", int'(bus0.m_valid), 0);
                rst_n = 1'b1;
                repeat (224) @(negedge clk);
            end else begin
                repeat (434) @(negedge clk);
            end
        end
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_partial", int'(lvl0), 0);
        send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("post_rst_data", int'(bus0.m_data), 8'h7E);
        chk("post_rst_level", int'(lvl0), 1);
        pop(0);
        chk("post_rst_drained", int'(lvl0), 0);

        // Even parity: wrong then correct parity bit
        send(2, 8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("par_bad_data", int'(bus2.m_data), 8'h3C);
        chk("par_bad_err", int'(bus2.m_err), 2'b10);
        pop(2);
        send(2, 8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("par_ok_data", int'(bus2.m_data), 8'h3C);
        chk("par_ok_err", int'(bus2.m_err), 2'b00);
        pop(2);

        // Fill 16-deep FIFO back-to-back, 17th character overruns
        o = ov_cnt1;
        for (int i = 0; i < 16; i++) send(1, 8'(i), 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("fill_level", int'(lvl1), 16);
        chk("fill_no_overrun", ov_cnt1 - o, 0);
        send(1, 8'h10, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("overrun_pulses", ov_cnt1 - o, 1);
        chk("overrun_level", int'(lvl1), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), int'(bus1.m_data), i);
            pop(1);
        end
        chk("drain_level", int'(lvl1), 0);
        chk("drain_valid", int'(bus1.m_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
